// File: rtl/delay_line_var.sv
// delay_line_var: multi-channel, runtime-programmable sample delay line.
// Each channel is delayed by De = min(delay_sel_i, MAX_DELAY) sample strobes
// using a circular buffer shared by all channels (one pointer set, one delay).
//
// Ports:
//   clk_i        system clock, rising edge
//   clr_i        synchronous active-high reset
//   en_i         sample strobe, one sample per channel per high cycle
//   flush_i      synchronous soft restart of pointer/fill state
//   delay_sel_i  requested delay in strobes (saturates at MAX_DELAY)
//   data_i       packed input samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_o       packed delayed samples, same packing
//   valid_o      one-cycle pulse when data_o was updated
//   primed_o     fill history covers the current delay
module delay_line_var #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned DSEL_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic                         clk_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic [DSEL_W-1:0]            delay_sel_i,
  input  logic [N_CH*DATA_WIDTH-1:0]   data_i,
  output logic [N_CH*DATA_WIDTH-1:0]   data_o,
  output logic                         valid_o,
  output logic                         primed_o
);

  localparam int unsigned BUS_W = N_CH * DATA_WIDTH;
  localparam int unsigned PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  // Wide enough to hold wr_ptr + MAX_DELAY without overflow.
  localparam int unsigned AW    = DSEL_W + 1;

  localparam logic [DSEL_W-1:0] MAX_D    = DSEL_W'(MAX_DELAY);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MAX_DELAY - 1);

  logic [BUS_W-1:0]  mem [MAX_DELAY];
  logic [PTR_W-1:0]  wr_ptr;
  logic [DSEL_W-1:0] fill_cnt;

  logic              strobe_c;
  logic              hist_ok_c;
  logic [DSEL_W-1:0] de_c;
  logic [DSEL_W-1:0] fill_nxt_c;
  logic [PTR_W-1:0]  wr_ptr_nxt_c;
  logic [PTR_W-1:0]  rd_idx_c;
  logic [AW-1:0]     wr_ext_c;
  logic [AW-1:0]     de_ext_c;

  // Effective delay, read index (modulo MAX_DELAY) and next pointer/fill state.
  always_comb begin
    de_c         = (delay_sel_i > MAX_D) ? MAX_D : delay_sel_i;
    strobe_c     = en_i & ~clr_i & ~flush_i;
    wr_ext_c     = AW'(wr_ptr);
    de_ext_c     = AW'(de_c);
    // De == MAX_DELAY lands on wr_ptr itself: the slot about to be overwritten.
    if (wr_ext_c >= de_ext_c) begin
      rd_idx_c = PTR_W'(wr_ext_c - de_ext_c);
    end else begin
      rd_idx_c = PTR_W'(wr_ext_c + AW'(MAX_DELAY) - de_ext_c);
    end
    wr_ptr_nxt_c = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    fill_nxt_c   = (en_i && (fill_cnt != MAX_D)) ? fill_cnt + DSEL_W'(1) : fill_cnt;
    hist_ok_c    = (fill_cnt >= de_c);
  end

  // Sample storage; intentionally not reset, reads are gated by fill_cnt.
  always_ff @(posedge clk_i) begin
    if (strobe_c) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointer, fill tracking and registered outputs.
  always_ff @(posedge clk_i) begin
    if (clr_i || flush_i) begin
      data_o   <= '0;
      valid_o  <= 1'b0;
      primed_o <= 1'b0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      valid_o  <= en_i;
      primed_o <= (fill_nxt_c >= de_c);
      if (en_i) begin
        if (de_c == '0) begin
          data_o <= data_i;
        end else if (hist_ok_c) begin
          data_o <= mem[rd_idx_c];
        end else begin
          data_o <= '0;
        end
        wr_ptr   <= wr_ptr_nxt_c;
        fill_cnt <= fill_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_var.sv
// Self-checking bench for delay_line_var: directed scenarios followed by
// randomized traffic, all compared against a queue-based history model.
module tb_delay_line_var;

  localparam int unsigned DATA_WIDTH = 24;
  localparam int unsigned N_CH       = 2;
  localparam int unsigned MAX_DELAY  = 16;
  localparam int unsigned DSEL_W     = $clog2(MAX_DELAY + 1);
  localparam int unsigned BUS_W      = N_CH * DATA_WIDTH;

  logic              clk_i = 1'b0;
  logic              clr_i = 1'b1;
  logic              en_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [DSEL_W-1:0] delay_sel_i = '0;
  logic [BUS_W-1:0]  data_i = '0;
  logic [BUS_W-1:0]  data_o;
  logic              valid_o;
  logic              primed_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: the last MAX_DELAY strobed samples since reset/flush.
  logic [BUS_W-1:0] hist[$];
  logic [BUS_W-1:0] exp_data;
  logic             exp_valid;
  logic             exp_primed;

  delay_line_var #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_CH       (N_CH),
    .MAX_DELAY  (MAX_DELAY)
  ) dut (
    .clk_i       (clk_i),
    .clr_i       (clr_i),
    .en_i        (en_i),
    .flush_i     (flush_i),
    .delay_sel_i (delay_sel_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .primed_o    (primed_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BUS_W-1:0] pk(input int ch0, input int ch1);
    return {24'(ch1), 24'(ch0)};
  endfunction

  // Model of one clock edge: sample delayed by De strobes, zero if not yet seen.
  task automatic model_edge(input logic c, input logic f, input logic e,
                            input logic [DSEL_W-1:0] s, input logic [BUS_W-1:0] d);
    int de;
    de = (int'(s) > int'(MAX_DELAY)) ? int'(MAX_DELAY) : int'(s);
    if (c || f) begin
      hist.delete();
      exp_data   = '0;
      exp_valid  = 1'b0;
      exp_primed = 1'b0;
    end else begin
      exp_valid = e;
      if (e) begin
        if (de == 0)              exp_data = d;
        else if (hist.size() >= de) exp_data = hist[hist.size() - de];
        else                      exp_data = '0;
        hist.push_back(d);
        if (hist.size() > MAX_DELAY) void'(hist.pop_front());
      end
      exp_primed = (hist.size() >= de);
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare 1 time unit later.
  task automatic cyc(input logic c, input logic f, input logic e,
                     input logic [DSEL_W-1:0] s, input logic [BUS_W-1:0] d);
    clr_i       = c;
    flush_i     = f;
    en_i        = e;
    delay_sel_i = s;
    data_i      = d;
    @(posedge clk_i);
    model_edge(c, f, e, s, d);
    #1;
    check("data_o",   64'(data_o),   64'(exp_data));
    check("valid_o",  64'(valid_o),  64'(exp_valid));
    check("primed_o", 64'(primed_o), 64'(exp_primed));
  endtask

  function automatic logic [BUS_W-1:0] rnd_data();
    return BUS_W'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [DSEL_W-1:0] sel;
    // Reset.
    cyc(1, 0, 0, 5'd0, '0);
    cyc(1, 0, 1, 5'd3, pk(77, 77));

    // Basic delay, D=3, strobe every cycle.
    for (int n = 1; n <= 20; n++) cyc(0, 0, 1, 5'd3, pk(n, n + 100));

    // Sparse strobes, D=2, one strobe in five cycles.
    cyc(0, 1, 0, 5'd2, '0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, 5'd2, pk(10 * k, 10 * k + 100));
      repeat (4) cyc(0, 0, 0, 5'd2, rnd_data());
    end

    // Bounds and wrap at D=16, then registered bypass at D=0.
    cyc(0, 1, 0, 5'd16, '0);
    for (int n = 1; n <= 40; n++) cyc(0, 0, 1, 5'd16, pk(n, n + 100));
    for (int n = 41; n <= 46; n++) cyc(0, 0, 1, 5'd0, pk(n, n + 100));

    // Saturation and live delay changes.
    for (int n = 47; n <= 66; n++) cyc(0, 0, 1, 5'd20, pk(n, n + 100));
    for (int n = 67; n <= 76; n++) cyc(0, 0, 1, 5'd4, pk(n, n + 100));
    cyc(0, 1, 0, 5'd4, '0);
    for (int n = 1; n <= 8; n++)  cyc(0, 0, 1, 5'd4,  pk(n, n + 100));
    for (int n = 9; n <= 20; n++) cyc(0, 0, 1, 5'd12, pk(n, n + 100));

    // Flush then clear mid-stream at D=5, each coincident with a strobe.
    for (int n = 21; n <= 30; n++) cyc(0, 0, 1, 5'd5, pk(n, n + 100));
    cyc(0, 1, 1, 5'd5, pk(999, 999));
    for (int n = 31; n <= 38; n++) cyc(0, 0, 1, 5'd5, pk(n, n + 100));
    for (int n = 39; n <= 48; n++) cyc(0, 0, 1, 5'd5, pk(n, n + 100));
    cyc(1, 0, 1, 5'd5, pk(888, 888));
    for (int n = 49; n <= 56; n++) cyc(0, 0, 1, 5'd5, pk(n, n + 100));

    // Randomized traffic with occasional delay changes, flushes and resets.
    sel = 5'd7;
    for (int i = 0; i < 3000; i++) begin
      logic c, f, e;
      if ($urandom_range(0, 19) == 0) sel = DSEL_W'($urandom_range(0, 31));
      c = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) < 7);
      cyc(c, f, e, sel, rnd_data());
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
